// File: rtl/prio_req_encoder_pkg.sv
// Shared constants and helpers for the
// priority request encoder.
package prio_pkg;

  localparam logic PRIO_FIXED = 1'b0;
  localparam logic PRIO_RR    = 1'b1;

  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_req_encoder_if.sv
// Output handshake bundle: the encoder offers
// an index, the consumer accepts it.
interface prio_req_encoder_if #(
  parameter int N = 8
);
  import prio_pkg::*;

  localparam int W = idx_w(N);

  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] out_idx_o;

  modport master (
    output out_valid_o,
    output out_idx_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o,
    input  out_idx_o,
    output out_ready_i
  );

endinterface

// File: rtl/prio_req_encoder_pick.sv
// Combinational picker: highest set bit, or a
// round-robin descent starting below start.
module prio_pick
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [N-1:0] mask;
  logic [N-1:0] low;
  logic         lo_hit;

  // RR mask: indices below start are searched first
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      if (mode == PRIO_RR && i < int'(start))
        mask[i] = 1'b1;
    end
  end

  assign low    = vec & mask;
  assign lo_hit = |low;

  // highest hit wins; fall back to full vector
  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (lo_hit ? low[i] : vec[i])
        idx = W'(i);
    end
  end

endmodule

// File: rtl/prio_req_encoder.sv
// Sticky request capture with a held output
// offer and fixed or round-robin selection.
module prio_req_encoder
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_i,
  input  logic           mode_i,
  output logic [N-1:0]   pending_o,
  output logic           overflow_o,
  prio_req_encoder_if.master bus
);

  logic [N-1:0] pending;
  logic [N-1:0] pend_nx;
  logic [N-1:0] clr;
  logic [W-1:0] rr_ptr;
  logic [W-1:0] rr_nx;
  logic [W-1:0] idx_q;
  logic [W-1:0] pick_idx;
  logic         valid_q;
  logic         ovf_q;
  logic         found;
  logic         hs;
  logic         load;

  assign hs   = valid_q & bus.out_ready_i;
  assign load = ~valid_q | bus.out_ready_i;

  // served bit to clear on handshake
  always_comb begin
    clr = '0;
    if (hs)
      clr[idx_q] = 1'b1;
  end

  assign pend_nx = (pending & ~clr) | req_i;
  assign rr_nx   = hs ? idx_q : rr_ptr;

  prio_pick #(.N(N)) u_pick (
    .vec   (pend_nx),
    .start (rr_nx),
    .mode  (mode_i),
    .found (found),
    .idx   (pick_idx)
  );

  // pending, pointer, overflow and output offer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      rr_ptr  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      pending <= pend_nx;
      rr_ptr  <= rr_nx;
      ovf_q   <= |(req_i & pending & ~clr);
      if (load) begin
        valid_q <= found;
        if (found)
          idx_q <= pick_idx;
      end
    end
  end

  assign bus.out_valid_o = valid_q;
  assign bus.out_idx_o   = idx_q;
  assign pending_o       = pending;
  assign overflow_o      = ovf_q;

endmodule

// File: doc/prio_req_encoder.md
Name: prio_req_encoder

Overview:
Parametrised N-input priority encoder with sticky request capture, an output valid/ready handshake, and a selectable fixed or round-robin priority mode. Single-cycle request pulses are latched into a pending vector. The block presents the winning index to a downstream consumer and clears the served bit only on handshake. It sits between event/interrupt sources and a single-consumer service unit.

Parameters:
- N, 8, number of request inputs; must be >= 2.
- W, $clog2(N), index width; localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_i  input  N  request pulses; each set bit is ORed into pending.
- mode_i  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- out_ready_i  input  1  consumer accepts out_idx_o this cycle.
- out_valid_o  output  1  out_idx_o holds a pending request.
- out_idx_o  output  W  index of the selected request.
- pending_o  output  N  current pending vector, for debug and status.
- overflow_o  output  1  one-cycle pulse: a request was lost because its bit was already pending.

Behaviour:
- Reset (async assert, sync release): pending = 0, out_valid_o = 0, out_idx_o = 0, overflow_o = 0, rr_ptr = 0. Outputs go to 0 immediately on rst_n falling, without a clock edge.
- Handshake: hs = out_valid_o & out_ready_i.
- clr = hs ? onehot(out_idx_o) : 0.
- pending_next = (pending & ~clr) | req_i. A request on the bit being cleared in the same cycle wins, so the bit stays set.
- Output register loads when (!out_valid_o | out_ready_i):
  - out_valid_o <= |pending_next.
  - out_idx_o <= pick(pending_next, mode_i, rr_ptr_next).
  - If pending_next = 0, out_idx_o keeps its old value.
- Stability: while out_valid_o=1 and out_ready_i=0, out_idx_o and out_valid_o hold. A higher-priority arrival does not pre-empt the index already offered.
- Latency: a request into an idle block gives out_valid_o=1 on the next edge. Throughput is one grant per cycle with out_ready_i held high.
- Fixed mode: the highest set index wins, so bit N-1 has top priority.
- Round-robin mode:
  - The search starts at index (rr_ptr - 1) mod N and descends, wrapping from 0 to N-1.
  - On hs, rr_ptr_next = out_idx_o; otherwise rr_ptr is unchanged.
  - With rr_ptr = 0 after reset, the first RR search order equals fixed order.
- Mode switch: takes effect at the next output-register load. rr_ptr keeps updating on hs in both modes.
- Overflow: overflow_o <= |(req_i & pending & ~clr), registered, so it pulses one cycle after the lost request. Lost requests are not counted; the bit remains pending once.
- All-zero request input: out_valid_o=0; no change to pending.
- Index arithmetic is modulo N. For N not a power of two, out_idx_o never exceeds N-1.

Decomposition:
- Shared package prio_pkg holds:
  - the mode constants PRIO_FIXED = 1'b0 and PRIO_RR = 1'b1;
  - the width function idx_w(n) = max(1, $clog2(n)).
- One combinational sub-module, prio_pick (parameter N):
  - Inputs: vector, start pointer, mode.
  - Outputs: found flag and index.
  - RR is built inside it as a masked search (indices below the start) with an unmasked fallback.

Test Plan:
- Fixed mode, ready=1, single pulse req_i=8'b0010_0100 → next edge valid=1, idx=5; then idx=2; then valid=0, pending=0.
- Backpressure: ready=0, bit 2 offered, then req_i[7] pulsed → idx stays 2, pending=8'h84. Raise ready → idx 2 accepted, next idx=7.
- Overflow: ready=0, pulse req_i[3] twice on separate cycles → overflow_o=1 for exactly one cycle after the second pulse. Releasing ready yields exactly one grant of 3.
- Same-cycle re-request: fixed mode, only bit 4 pending, hs on idx 4 with req_i[4]=1 → pending[4] stays 1, overflow_o=0, idx 4 offered again.
- Mode comparison: req_i=8'hFF held every cycle, ready=1:
  - fixed → idx 7 every cycle;
  - RR → 7,6,5,4,3,2,1,0,7 repeating.
- Async reset mid-operation: pending=8'hA5, valid=1, drop rst_n between edges → all outputs 0 immediately. After release with req_i=0 → valid stays 0; first RR grant after a new req_i=8'hFF is 7.
